uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Synthesizable, parametrised UART receiver for the lab FPGA designs; it replaces the simulation-only serial model on the receive path.
- Derives a 16x oversample tick from the system clock and majority-votes each bit.
- Supports 5–9 data bits, none/odd/even parity, and 1 or 2 stop bits.
- Delivers each word with a valid/ready handshake, error flags, overrun detection and break detection.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate.
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line, idle high.
- rx_ready  in  1  consumer accepts the held word this cycle.
- clr_err  in  1  one-cycle pulse; clears sticky overrun.
- rx_data  out  DATA_BITS  received word, LSB first on the line.
- rx_valid  out  1  held word valid.
- parity_err  out  1  parity mismatch for the held word.
- frame_err  out  1  a stop bit sampled low for the held word.
- overrun  out  1  sticky; a word was dropped.
- break_det  out  1  one-cycle pulse on break.

Behaviour:
- Reset:
  - rst is synchronous, active-high, and acts on any cycle, including mid-frame.
  - FSM goes to IDLE; tick and sample counters go to 0; both synchronizer flops go to 1.
  - rx_data=0; rx_valid, parity_err, frame_err, overrun and break_det all go to 0.
- Synchronizer: rx passes through two flops; all logic uses the second flop (rs).
- Tick: DIV = CLK_HZ/(BAUD*16), integer division. The divider counts 0..DIV-1 and pulses tick when it wraps. The divider is held at 0 in IDLE.
- Sampling:
  - A 4-bit sample counter advances on each tick.
  - Bit value = majority of rs at sample counts 7, 8 and 9.
  - The bit ends at count 15.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRKWAIT.
  - IDLE: on rs = 0, go to START and clear the counters.
  - START: if the voted bit is 1 (glitch), go to IDLE with no output; else go to DATA.
  - DATA: shift in DATA_BITS bits, LSB first, into a shift register. Then go to PARITY if PARITY != 0, else STOP.
  - PARITY: compute err = XOR(data, pbit) for even, or ~XOR(data, pbit) for odd.
  - STOP: sample STOP_BITS stop bits; ferr = 1 if any stop bit votes 0.
  - Word completion happens at the voted sample of the final stop bit, not at bit end, so back-to-back frames are tolerated.
  - After completion: go to BRKWAIT if break, else IDLE.
  - BRKWAIT: stay until rs = 1, then go to IDLE. No new start bits are detected while in BRKWAIT.
- Break:
  - Condition: all data bits 0, parity bit (if present) 0, and the final stop bit 0.
  - break_det pulses high for 1 cycle, coincident with the completion cycle.
  - The word is still delivered, with data=0 and frame_err=1.
- Delivery, evaluated in the cycle after the completion tick:
  - If rx_valid=0, or (rx_valid & rx_ready) this same cycle:
    - Load rx_data, parity_err and frame_err; set rx_valid=1.
    - Simultaneous accept and new word therefore keeps rx_valid high with the new data.
  - Else: the new word is discarded; overrun=1; the held word and its flags are unchanged.
- Handshake: on rx_valid & rx_ready with no new word, rx_valid goes to 0 next cycle. rx_data and the error flags hold their last values.
- overrun: cleared only by rst or clr_err. If clr_err and a new overrun occur in the same cycle, overrun stays set.
- Latency: rx_valid rises 1 clk after the tick at sample 9 of the final stop bit.

Test Plan:
- Common setup: CLK_HZ=18_432_000 and BAUD=115200, giving DIV=10 and a bit time of 160 clk.
- 8N1, rx_ready=1, send 0x55 → rx_valid high for exactly 1 cycle, rx_data=0x55, parity_err=0 and frame_err=0. rx_valid rises 1+9×160+(9×10+1) clk after the start edge, ±3 clk of synchronizer/detect latency.
- PARITY=2, send 0xA3 with parity bit 0 → no error. Resend with parity bit 1 → rx_data=0xA3, parity_err=1. Repeat with PARITY=1 and check the inverted results.
- STOP_BITS=2, send 0x3C with the second stop bit driven 0 → frame_err=1, rx_data=0x3C. Next, a clean frame 0x3D → frame_err=0.
- rx_ready=0, send 0x11 then 0x22 → rx_data stays 0x11, overrun=1. Then clr_err pulse → overrun=0. Then rx_ready=1 → rx_valid drops.
- Low glitch of 20 clk on idle rx → no rx_valid, FSM back in IDLE. A following 0x7E frame is received correctly.
- Hold rx low for 3 frame times → exactly one rx_valid with data=0 and frame_err=1, plus one break_det pulse. No further words until rx returns high, then a 0x01 frame is received. Separately, assert rst mid-frame → all outputs are 0 the next cycle, and the remainder of the interrupted frame produces no word.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver with majority vote per bit,
// 5..9 data bits, optional parity, 1 or 2 stop bits, valid/ready delivery,
// sticky overrun and break detection.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | line idle, waiting for a low level on rs
// S_START   | validating the start bit, a high vote means a glitch
// S_DATA    | shifting in DATA_BITS bits, LSB first
// S_PARITY  | sampling the parity bit and computing the error
// S_STOP    | sampling stop bits, word completes at the last vote
// S_BRKWAIT | break seen, waiting for the line to return high
module uart_rx_os #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [3:0] N_DATA = 4'(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRKWAIT
  } state_t;

  state_t state;

  logic rx_meta;
  logic rs;

  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       samp_cnt;
  logic             run;
  logic             tick;
  logic             take_s7;
  logic             take_s8;
  logic             vote_now;
  logic             bit_end;
  logic             s7;
  logic             s8;
  logic             vote;

  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_cnt;
  logic                 pbit;
  logic                 perr_acc;
  logic                 ferr_acc;
  logic                 stop_idx;
  logic                 last_stop;
  logic                 brk;

  logic                 done;
  logic [DATA_BITS-1:0] done_data;
  logic                 done_perr;
  logic                 done_ferr;

  // samp_cnt counts ticks into the current bit. The tick that moves it to
  // 7, 8 and 9 takes the three samples; the tick leaving 15 ends the bit.
  assign run      = (state == S_START) || (state == S_DATA) ||
                    (state == S_PARITY) || (state == S_STOP);
  assign tick     = run && (div_cnt == DIV_LAST);
  assign take_s7  = tick && (samp_cnt == 4'd6);
  assign take_s8  = tick && (samp_cnt == 4'd7);
  assign vote_now = tick && (samp_cnt == 4'd8);
  assign bit_end  = tick && (samp_cnt == 4'd15);
  assign vote     = (s7 & s8) | (s7 & rs) | (s8 & rs);

  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  assign brk       = (shreg == '0) && !pbit && !vote;

  // Two-flop synchronizer; everything downstream uses rs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
    end
  end

  // Oversample divider and sample counter, parked at zero outside a frame.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      samp_cnt <= samp_cnt + 4'd1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // First two of the three mid-bit samples; the third is rs itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      s7 <= 1'b1;
      s8 <= 1'b1;
    end else begin
      if (take_s7) s7 <= rs;
      if (take_s8) s8 <= rs;
    end
  end

  // Frame FSM; produces a one-cycle completion pulse with the word and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      pbit      <= 1'b0;
      perr_acc  <= 1'b0;
      ferr_acc  <= 1'b0;
      stop_idx  <= 1'b0;
      done      <= 1'b0;
      done_data <= '0;
      done_perr <= 1'b0;
      done_ferr <= 1'b0;
      break_det <= 1'b0;
    end else begin
      done      <= 1'b0;
      break_det <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rs) begin
            state    <= S_START;
            bit_cnt  <= '0;
            pbit     <= 1'b0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
            stop_idx <= 1'b0;
          end
        end
        S_START: begin
          if (vote_now && vote) state <= S_IDLE;
          else if (bit_end) state <= S_DATA;
        end
        S_DATA: begin
          if (vote_now) begin
            shreg   <= {vote, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
          if (bit_end && (bit_cnt == N_DATA))
            state <= (PARITY != 0) ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          if (vote_now) begin
            pbit     <= vote;
            perr_acc <= (PARITY == 1) ? ~(^{shreg, vote}) : (^{shreg, vote});
          end
          if (bit_end) state <= S_STOP;
        end
        S_STOP: begin
          // Completing at the vote rather than at bit end leaves half a bit
          // of slack for a following start edge.
          if (vote_now) begin
            if (!last_stop) begin
              ferr_acc <= ferr_acc | ~vote;
              stop_idx <= 1'b1;
            end else begin
              done      <= 1'b1;
              done_data <= shreg;
              done_perr <= perr_acc;
              done_ferr <= ferr_acc | ~vote;
              if (brk) begin
                break_det <= 1'b1;
                state     <= S_BRKWAIT;
              end else begin
                state     <= S_IDLE;
              end
            end
          end
        end
        S_BRKWAIT: begin
          if (rs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Delivery and handshake; a word arriving while one is still held is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (clr_err) overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= done_data;
          parity_err <= done_perr;
          frame_err  <= done_ferr;
          rx_valid   <= 1'b1;
        end else begin
          overrun    <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed frames into four receiver configurations
// (8N1, 8E1, 8O1, 8N2) sharing one serial line.
module tb_uart_rx_os;

  localparam int CLK_HZ = 18_432_000;
  localparam int BAUD   = 115200;
  localparam int BIT    = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic rx_ready = 1'b1;
  logic clr_err = 1'b0;

  logic [7:0] d_n, d_e, d_o, d_2;
  logic v_n, v_e, v_o, v_2;
  logic pe_n, pe_e, pe_o, pe_2;
  logic fe_n, fe_e, fe_o, fe_2;
  logic ov_n, ov_e, ov_o, ov_2;
  logic bk_n, bk_e, bk_o, bk_2;

  uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_ready(rx_ready), .clr_err(clr_err),
    .rx_data(d_n), .rx_valid(v_n), .parity_err(pe_n), .frame_err(fe_n),
    .overrun(ov_n), .break_det(bk_n));

  uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst(rst), .rx(rx), .rx_ready(rx_ready), .clr_err(clr_err),
    .rx_data(d_e), .rx_valid(v_e), .parity_err(pe_e), .frame_err(fe_e),
    .overrun(ov_e), .break_det(bk_e));

  uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_o (
    .clk(clk), .rst(rst), .rx(rx), .rx_ready(rx_ready), .clr_err(clr_err),
    .rx_data(d_o), .rx_valid(v_o), .parity_err(pe_o), .frame_err(fe_o),
    .overrun(ov_o), .break_det(bk_o));

  uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_2 (
    .clk(clk), .rst(rst), .rx(rx), .rx_ready(rx_ready), .clr_err(clr_err),
    .rx_data(d_2), .rx_valid(v_2), .parity_err(pe_2), .frame_err(fe_2),
    .overrun(ov_2), .break_det(bk_2));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor on the 8N1 instance: word count, valid-high cycles, break pulses.
  int cyc = 0;
  int words = 0;
  int vcycles = 0;
  int brks = 0;
  int rise_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic last_ferr = 1'b0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (v_n) vcycles++;
    if (v_n && !prev_v) begin
      words++;
      rise_cyc  = cyc;
      last_data = d_n;
      last_ferr = fe_n;
    end
    if (bk_n) brks++;
    prev_v = v_n;
  end

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  int t0;
  int w0;
  int b0;
  int v0;
  int lat;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(d_n), 32'h0);
    chk("rst_valid", 32'(v_n), 32'h0);
    chk("rst_perr", 32'(pe_n), 32'h0);
    chk("rst_ferr", 32'(fe_n), 32'h0);
    chk("rst_ovr", 32'(ov_n), 32'h0);
    chk("rst_brk", 32'(bk_n), 32'h0);
    rst = 1'b0;
    idle_bits(2);

    // 8N1 0x55 with latency window 1532 +/- 3
    w0 = words; v0 = vcycles; t0 = cyc;
    send({6'b0, 1'b1, 8'h55, 1'b0}, 10);
    idle_bits(12);
    lat = rise_cyc - t0;
    chk("n1_words", 32'(words - w0), 32'd1);
    chk("n1_vcycles", 32'(vcycles - v0), 32'd1);
    chk("n1_data", 32'(last_data), 32'h55);
    chk("n1_lat_win", 32'((lat >= 1529) && (lat <= 1535)), 32'd1);
    chk("n1_ferr", 32'(last_ferr), 32'd0);

    // 0xA3 has four ones: parity bit 0 is even-correct, odd-wrong
    send({5'b0, 1'b1, 1'b0, 8'hA3, 1'b0}, 11);
    chk("e_p0_data", 32'(d_e), 32'hA3);
    chk("e_p0_perr", 32'(pe_e), 32'd0);
    chk("e_p0_ferr", 32'(fe_e), 32'd0);
    chk("o_p0_perr", 32'(pe_o), 32'd1);
    idle_bits(12);
    send({5'b0, 1'b1, 1'b1, 8'hA3, 1'b0}, 11);
    chk("e_p1_perr", 32'(pe_e), 32'd1);
    chk("e_p1_data", 32'(d_e), 32'hA3);
    chk("o_p1_perr", 32'(pe_o), 32'd0);
    chk("o_p1_data", 32'(d_o), 32'hA3);
    idle_bits(12);

    // Two stop bits: second stop low, then a clean frame
    send({5'b0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    chk("s2_bad_ferr", 32'(fe_2), 32'd1);
    chk("s2_bad_data", 32'(d_2), 32'h3C);
    idle_bits(12);
    send({5'b0, 1'b1, 1'b1, 8'h3D, 1'b0}, 11);
    chk("s2_ok_ferr", 32'(fe_2), 32'd0);
    chk("s2_ok_data", 32'(d_2), 32'h3D);
    idle_bits(12);

    // 20-clk glitch produces nothing, following frame is clean
    w0 = words;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle_bits(2);
    chk("glitch_words", 32'(words - w0), 32'd0);
    send({6'b0, 1'b1, 8'h7E, 1'b0}, 10);
    idle_bits(12);
    chk("glitch_next_words", 32'(words - w0), 32'd1);
    chk("glitch_next_data", 32'(last_data), 32'h7E);
    chk("glitch_next_ferr", 32'(last_ferr), 32'd0);

    // Break: line low for three frame times
    w0 = words; b0 = brks;
    rx = 1'b0;
    repeat (30 * BIT) @(negedge clk);
    chk("brk_words", 32'(words - w0), 32'd1);
    chk("brk_data", 32'(last_data), 32'h00);
    chk("brk_ferr", 32'(last_ferr), 32'd1);
    chk("brk_pulses", 32'(brks - b0), 32'd1);
    idle_bits(2);
    send({6'b0, 1'b1, 8'h01, 1'b0}, 10);
    idle_bits(12);
    chk("brk_next_words", 32'(words - w0), 32'd2);
    chk("brk_next_data", 32'(last_data), 32'h01);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    send({6'b0, 1'b1, 8'h11, 1'b0}, 10);
    send({6'b0, 1'b1, 8'h22, 1'b0}, 10);
    idle_bits(2);
    chk("ovr_data", 32'(d_n), 32'h11);
    chk("ovr_valid", 32'(v_n), 32'd1);
    chk("ovr_flag", 32'(ov_n), 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("ovr_clr", 32'(ov_n), 32'd0);
    chk("ovr_clr_valid", 32'(v_n), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("ovr_accept_valid", 32'(v_n), 32'd0);
    chk("ovr_accept_data", 32'(d_n), 32'h11);
    idle_bits(2);

    // Reset mid-frame (100 clk into a start bit)
    rx_ready = 1'b0;
    send({6'b0, 1'b1, 8'h5A, 1'b0}, 10);
    send({6'b0, 1'b1, 8'h6B, 1'b0}, 10);
    idle_bits(2);
    chk("pre_rst_valid", 32'(v_n), 32'd1);
    chk("pre_rst_ovr", 32'(ov_n), 32'd1);
    w0 = words;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_data", 32'(d_n), 32'h0);
    chk("mid_rst_valid", 32'(v_n), 32'd0);
    chk("mid_rst_perr", 32'(pe_n), 32'd0);
    chk("mid_rst_ferr", 32'(fe_n), 32'd0);
    chk("mid_rst_ovr", 32'(ov_n), 32'd0);
    chk("mid_rst_brk", 32'(bk_n), 32'd0);
    repeat (BIT - 101) @(negedge clk);
    idle_bits(12);
    chk("mid_rst_words", 32'(words - w0), 32'd0);
    chk("mid_rst_valid_after", 32'(v_n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
